// File: rtl/prefetch_fifo_if.sv
// Handshake bundle between the cache read stage / decoder and the prefetch buffer.
interface prefetch_fifo_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              pr_reset;
   logic              prefetchfifo_write_do;
   logic [35:0]       prefetchfifo_write_data;
   logic              prefetchfifo_signal_limit_do;
   logic              prefetchfifo_signal_pf_do;
   logic [ADDR_W:0]   prefetchfifo_used;
   logic              prefetchfifo_overflow;
   logic              fetch_valid;
   logic [31:0]       fetch_data;
   logic [2:0]        fetch_length;
   logic              fetch_limit;
   logic              fetch_page_fault;
   logic              fetch_consume_do;
   logic [2:0]        fetch_consume_len;

   modport master (
      output pr_reset, prefetchfifo_write_do, prefetchfifo_write_data,
             prefetchfifo_signal_limit_do, prefetchfifo_signal_pf_do,
             fetch_consume_do, fetch_consume_len,
      input  prefetchfifo_used, prefetchfifo_overflow, fetch_valid, fetch_data,
             fetch_length, fetch_limit, fetch_page_fault
   );

   modport slave (
      input  pr_reset, prefetchfifo_write_do, prefetchfifo_write_data,
             prefetchfifo_signal_limit_do, prefetchfifo_signal_pf_do,
             fetch_consume_do, fetch_consume_len,
      output prefetchfifo_used, prefetchfifo_overflow, fetch_valid, fetch_data,
             fetch_length, fetch_limit, fetch_page_fault
   );
endinterface

// File: rtl/prefetch_fifo.sv
// Code-byte prefetch buffer: circular entry store with a registered, partially
// consumable head entry presented to the decoder.
module prefetch_fifo #(
   parameter int unsigned ADDR_W = 4
) (
   input logic            clk,
   input logic            rst_n,
   prefetch_fifo_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [3:0]  LEN_LIMIT = 4'hF;
   localparam logic [3:0]  LEN_PF    = 4'hE;

   logic [35:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d, valid_q, valid_d, limit_q, limit_d, pf_q, pf_d;
   logic [2:0]        len_q, len_d;
   logic [31:0]       data_q, data_d;
   logic              wr_req, full, consume, pop, partial, accept, load_en, load_code;
   logic [35:0]       wr_entry, load_entry;

   // Single write per cycle: page fault beats limit beats code.
   always_comb begin
      wr_req   = bus.prefetchfifo_signal_pf_do | bus.prefetchfifo_signal_limit_do |
                 bus.prefetchfifo_write_do;
      wr_entry = bus.prefetchfifo_write_data;
      if (bus.prefetchfifo_signal_pf_do)         wr_entry = {LEN_PF, 32'h0};
      else if (bus.prefetchfifo_signal_limit_do) wr_entry = {LEN_LIMIT, 32'h0};
   end

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign consume = valid_q & ~limit_q & ~pf_q & bus.fetch_consume_do &
                    (bus.fetch_consume_len != 3'd0);
   assign pop     = consume & (bus.fetch_consume_len >= len_q);
   assign partial = consume & ~pop;
   assign accept  = wr_req & (~full | pop);
   assign rd_next = rd_ptr_q + ADDR_W'(1);

   // Next state; a popped head refills from storage, or bypasses the incoming write.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      valid_d    = valid_q;
      limit_d    = limit_q;
      pf_d       = pf_q;
      len_d      = len_q;
      data_d     = data_q;
      load_en    = 1'b0;
      load_entry = wr_entry;
      load_code  = 1'b0;
      if (bus.pr_reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         valid_d  = 1'b0;
         limit_d  = 1'b0;
         pf_d     = 1'b0;
         len_d    = '0;
         data_d   = '0;
      end else begin
         if (accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (pop)    rd_ptr_d = rd_next;
         cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
         if (wr_req && full && !pop) ovf_d = 1'b1;
         if (partial) begin
            data_d = data_q >> {bus.fetch_consume_len, 3'b000};
            len_d  = len_q - bus.fetch_consume_len;
         end
         if (pop) begin
            if (cnt_q > CNT_W'(1)) begin
               load_en    = 1'b1;
               load_entry = mem_q[rd_next];
            end else if (accept) begin
               load_en = 1'b1;
            end else begin
               valid_d = 1'b0;
               limit_d = 1'b0;
               pf_d    = 1'b0;
               len_d   = '0;
               data_d  = '0;
            end
         end else if (!valid_q && accept) begin
            load_en = 1'b1;
         end
         if (load_en) begin
            load_code = (load_entry[35:32] != LEN_LIMIT) && (load_entry[35:32] != LEN_PF);
            valid_d   = 1'b1;
            limit_d   = (load_entry[35:32] == LEN_LIMIT);
            pf_d      = (load_entry[35:32] == LEN_PF);
            len_d     = load_code ? load_entry[34:32] : 3'd0;
            data_d    = load_code ? load_entry[31:0] : 32'h0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !bus.pr_reset) mem_q[wr_ptr_q] <= wr_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         limit_q  <= 1'b0;
         pf_q     <= 1'b0;
         len_q    <= '0;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         limit_q  <= limit_d;
         pf_q     <= pf_d;
         len_q    <= len_d;
         data_q   <= data_d;
      end
   end

   assign bus.prefetchfifo_used     = cnt_q;
   assign bus.prefetchfifo_overflow = ovf_q;
   assign bus.fetch_valid           = valid_q;
   assign bus.fetch_data            = data_q;
   assign bus.fetch_length          = len_q;
   assign bus.fetch_limit           = limit_q;
   assign bus.fetch_page_fault      = pf_q;
endmodule
